// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, FSM states, parity modes, STATUS bit positions.
package uart_pkg;

  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_DIV    = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_IRQ_EN = 8'h0C;

  localparam int DIV_W = 16;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_BUSY      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FERR      = 3;
  localparam int STAT_PERR      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

endpackage

// File: rtl/uart_rx_fifo_t_if.sv
// Peripheral bus port of the UART receiver: qualified strobes, byte address, write and read data.
interface uart_rx_fifo_t_if;
  logic        wen;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wen, output ren, output addr, output wdata, input rdata);
  modport slave  (input wen, input ren, input addr, input wdata, output rdata);
endinterface

// File: rtl/sync_fifo_t.sv
// Single-clock FIFO with combinational head; a pop frees a slot for a push on the same edge.
module sync_fifo_t #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_rx_fifo_t.sv
// UART receiver with RX FIFO, optional parity, sticky error flags and a level interrupt.
// Bus reads return one clock after the strobe; reading DATA pops the FIFO head.
module uart_rx_fifo_t
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY      = 0,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  uart_rx_fifo_t_if.slave  bus,
  input  logic             rx,
  output logic             irq
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic rx_meta_q, rx_sync_q, rx_dly_q;
  logic rx_fall;

  rx_state_e              state_q;
  logic [DIV_W-1:0]       cnt_q;
  logic [2:0]             bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_err_q;
  logic                   push_q, set_ferr_q, set_perr_q;
  logic                   exp_par;

  logic [DIV_W-1:0] clk_div_q;
  logic [1:0]       irq_en_q;
  logic             ovr_q, ferr_q, perr_q, irq_q;
  logic [31:0]      rdata_q, rdata_d, status_w;

  logic [7:0] offs;
  logic wr_div, wr_ien, w1c, rd_pop, set_ovr, busy;

  logic [DATA_BITS-1:0] head;
  logic                 full, empty;
  logic [LW:0]          level;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.addr[31:8], bus.wdata[31:16]};

  assign offs   = bus.addr[7:0];
  assign wr_div = bus.wen & (offs == REG_DIV);
  assign wr_ien = bus.wen & (offs == REG_IRQ_EN);
  assign w1c    = bus.wen & (offs == REG_STATUS);
  assign rd_pop = bus.ren & (offs == REG_DATA);
  assign busy   = (state_q != ST_IDLE);

  // Third flop only remembers the previous synchronised level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_dly_q  <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_dly_q  <= rx_sync_q;
    end
  end
  assign rx_fall = rx_dly_q & ~rx_sync_q;

  assign exp_par = (PARITY == int'(PAR_ODD)) ? ~^shift_q : ^shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      push_q     <= 1'b0;
      set_ferr_q <= 1'b0;
      set_perr_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      set_ferr_q <= 1'b0;
      set_perr_q <= 1'b0;
      if (wr_div) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_fall) begin
              state_q <= ST_START;
              cnt_q   <= clk_div_q >> 1;
            end
          end
          ST_START: begin
            if (cnt_q == '0) begin
              if (!rx_sync_q) begin
                state_q   <= ST_DATA;
                cnt_q     <= clk_div_q;
                bit_idx_q <= '0;
                par_err_q <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_DATA: begin
            if (cnt_q == '0) begin
              shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
              cnt_q   <= clk_div_q;
              if (bit_idx_q == BIT_LAST) begin
                state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_PARITY: begin
            if (cnt_q == '0) begin
              par_err_q <= (rx_sync_q != exp_par);
              cnt_q     <= clk_div_q;
              state_q   <= ST_STOP;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_STOP: begin
            if (cnt_q == '0) begin
              if (rx_sync_q) begin
                if (par_err_q) set_perr_q <= 1'b1;
                else           push_q     <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                set_ferr_q <= 1'b1;
                state_q    <= ST_BREAK;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_BREAK: begin
            if (rx_sync_q) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  sync_fifo_t #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push_q),
    .push_dat_i(shift_q),
    .pop_i     (rd_pop),
    .head_o    (head),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level)
  );

  // A same-cycle pop makes room, so only an unrelieved full FIFO overruns.
  assign set_ovr = push_q & full & ~(rd_pop & ~empty);

  always_comb begin
    status_w                 = '0;
    status_w[STAT_NOT_EMPTY] = ~empty;
    status_w[STAT_BUSY]      = busy;
    status_w[STAT_OVERRUN]   = ovr_q;
    status_w[STAT_FERR]      = ferr_q;
    status_w[STAT_PERR]      = perr_q;
    status_w[15:8]           = 8'(level);
  end

  always_comb begin
    rdata_d = '0;
    case (offs)
      REG_DATA:   rdata_d = empty ? 32'd0 : {23'd0, 1'b1, 8'(head)};
      REG_DIV:    rdata_d = 32'(clk_div_q);
      REG_STATUS: rdata_d = status_w;
      REG_IRQ_EN: rdata_d = {30'd0, irq_en_q};
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_div_q <= DIV_W'(DEFAULT_DIV);
      irq_en_q  <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (wr_div) clk_div_q <= bus.wdata[DIV_W-1:0];
      if (wr_ien) irq_en_q  <= bus.wdata[1:0];
      ovr_q  <= set_ovr    | (ovr_q  & ~(w1c & bus.wdata[STAT_OVERRUN]));
      ferr_q <= set_ferr_q | (ferr_q & ~(w1c & bus.wdata[STAT_FERR]));
      perr_q <= set_perr_q | (perr_q & ~(w1c & bus.wdata[STAT_PERR]));
      irq_q  <= (irq_en_q[0] & ~empty) | (irq_en_q[1] & (ovr_q | ferr_q | perr_q));
      if (bus.ren) rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_t.sv
// Directed bench: dut0 (4-deep, no parity) and dut1 (16-deep, even parity) share one bus.
module tb_uart_rx_fifo_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen, ren;
  logic [31:0] addr, wdata;
  logic        rx_line;
  logic        rx0, rx1, irq0, irq1;
  int          sel;
  int          bitp;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] held;

  always #5 clk = ~clk;

  uart_rx_fifo_t_if bus0 ();
  uart_rx_fifo_t_if bus1 ();

  assign bus0.wen   = wen;
  assign bus0.ren   = ren;
  assign bus0.addr  = addr;
  assign bus0.wdata = wdata;
  assign bus1.wen   = wen;
  assign bus1.ren   = ren;
  assign bus1.addr  = addr;
  assign bus1.wdata = wdata;

  assign rx0 = (sel == 0) ? rx_line : 1'b1;
  assign rx1 = (sel == 1) ? rx_line : 1'b1;

  uart_rx_fifo_t #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .DEFAULT_DIV(8)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .rx(rx0), .irq(irq0)
  );

  uart_rx_fifo_t #(.DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(2), .DEFAULT_DIV(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .rx(rx1), .irq(irq1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    @(negedge clk);
    ren  = 1'b1;
    addr = {24'd0, a};
    @(negedge clk);
    ren  = 1'b0;
    addr = '0;
    d = (sel == 1) ? bus1.rdata : bus0.rdata;
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    wen   = 1'b1;
    addr  = {24'd0, a};
    wdata = v;
    @(negedge clk);
    wen   = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (bitp) @(negedge clk);
  endtask

  // par < 0 omits the parity bit; a 1 stop bit is followed by two idle bit times.
  task automatic send_frame(input logic [7:0] d, input int par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par >= 0) send_bit(par[0]);
    send_bit(stop);
    if (stop) repeat (2 * bitp) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    wen     = 1'b0;
    ren     = 1'b0;
    addr    = '0;
    wdata   = '0;
    rx_line = 1'b1;
    sel     = 0;
    bitp    = 9;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset_rdata", bus0.rdata, 32'h0);
    check("reset_irq", {31'd0, irq0}, 32'h0);
    rd_chk(8'h08, 32'h0, "reset_status");
    rd_chk(8'h04, 32'h8, "reset_div");
    rd_chk(8'h0C, 32'h0, "reset_irq_en");
    rd_chk(8'h20, 32'h0, "unmapped_read");

    // Single 8N1 byte
    wr(8'h04, 32'd3);
    bitp = 4;
    rd_chk(8'h04, 32'h3, "div_written");
    send_frame(8'hA5, -1, 1'b1);
    rd_chk(8'h08, 32'h0101, "a5_status");
    check("a5_irq_off", {31'd0, irq0}, 32'h0);
    rd_chk(8'h00, 32'h1A5, "a5_data");
    held = bus0.rdata;
    repeat (5) @(negedge clk);
    check("rdata_hold", bus0.rdata, held);
    rd_chk(8'h08, 32'h0, "a5_status_after");
    rd_chk(8'h00, 32'h0, "a5_empty_read");

    // Overrun on a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), -1, 1'b1);
    rd_chk(8'h08, 32'h0405, "ovr_status");
    rd_chk(8'h00, 32'h101, "ovr_data1");
    rd_chk(8'h00, 32'h102, "ovr_data2");
    rd_chk(8'h00, 32'h103, "ovr_data3");
    rd_chk(8'h00, 32'h104, "ovr_data4");
    rd_chk(8'h00, 32'h0, "ovr_data_empty");
    rd_chk(8'h08, 32'h0004, "ovr_sticky");
    wr(8'h08, 32'h04);
    rd_chk(8'h08, 32'h0, "ovr_w1c");

    // Framing error, BREAK, error interrupt
    wr(8'h0C, 32'h2);
    rd_chk(8'h0C, 32'h2, "irq_en_written");
    send_frame(8'h55, -1, 1'b0);
    repeat (2 * bitp) @(negedge clk);
    rd_chk(8'h08, 32'h000A, "ferr_break_status");
    check("ferr_irq", {31'd0, irq0}, 32'h1);
    rx_line = 1'b1;
    repeat (bitp) @(negedge clk);
    rd_chk(8'h08, 32'h0008, "ferr_idle_status");
    wr(8'h08, 32'h08);
    repeat (3) @(negedge clk);
    check("ferr_irq_cleared", {31'd0, irq0}, 32'h0);
    rd_chk(8'h08, 32'h0, "ferr_w1c");

    // Even parity on dut1
    sel = 1;
    send_frame(8'h03, 1, 1'b1);
    rd_chk(8'h08, 32'h0010, "perr_status");
    send_frame(8'h03, 0, 1'b1);
    rd_chk(8'h08, 32'h0111, "par_ok_status");
    rd_chk(8'h00, 32'h103, "par_ok_data");
    wr(8'h08, 32'h10);
    rd_chk(8'h08, 32'h0, "perr_w1c");
    sel = 0;

    // Start-bit glitch
    wr(8'h04, 32'd15);
    bitp = 16;
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    rd_chk(8'h08, 32'h0002, "glitch_busy");
    repeat (30) @(negedge clk);
    rd_chk(8'h08, 32'h0, "glitch_status");

    // Reset mid-frame, then a clean frame at the default divider
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rd_chk(8'h08, 32'h0002, "midframe_busy");
    @(negedge clk);
    reset = 1'b1;
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bitp = 9;
    rd_chk(8'h08, 32'h0, "post_reset_status");
    rd_chk(8'h04, 32'h8, "post_reset_div");
    send_frame(8'h3C, -1, 1'b1);
    rd_chk(8'h08, 32'h0101, "post_reset_frame_status");
    rd_chk(8'h00, 32'h13C, "post_reset_frame_data");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
